// File: rtl/fsub4_seq_pkg.sv
// rtl/fsub4_seq_pkg.sv - shared state encoding and default width for the serial subtractor
package fsub4_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/band.sv
// rtl/band.sv - two-input and gate
module band (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/bor.sv
// rtl/bor.sv - two-input or gate
module bor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/bxor.sv
// rtl/bxor.sv - two-input xor gate
module bxor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/fsub1.sv
// rtl/fsub1.sv - one-bit full subtractor built from xor/and/or gates
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic r,
  output logic bout
);

  logic a_x_b;
  logic a_n;
  logic eq_n;
  logic gen;
  logic prop;

  bxor u_x1 (.a(a),     .b(b),    .y(a_x_b));
  bxor u_x2 (.a(a_x_b), .b(bin),  .y(r));

  // Inversions are xor with constant one so only the gate library is used.
  bxor u_na (.a(a),     .b(1'b1), .y(a_n));
  bxor u_ne (.a(a_x_b), .b(1'b1), .y(eq_n));

  band u_g  (.a(a_n),   .b(b),    .y(gen));
  band u_p  (.a(eq_n),  .b(bin),  .y(prop));
  bor  u_o  (.a(gen),   .b(prop), .y(bout));

endmodule

// File: rtl/fsub4_seq.sv
// rtl/fsub4_seq.sv - bit-serial subtractor, one bit per cycle LSB first, registered result
module fsub4_seq
  import fsub4_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             bout
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             bit_diff;
  logic             bit_borrow;
  logic             accept;
  logic             last_bit;

  assign last_bit = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  fsub1 u_bit (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .bin  (borrow),
    .r    (bit_diff),
    .bout (bit_borrow)
  );

  always_comb begin
    work_next      = work;
    work_next[idx] = bit_diff;
  end

  // r/bout load only on the final bit so they never expose a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      work   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      r      <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      idx    <= '0;
      borrow <= 1'b0;
    end else if (state == CALC) begin
      work   <= work_next;
      borrow <= bit_borrow;
      idx    <= last_bit ? '0 : idx + IDX_W'(1);
      if (last_bit) begin
        r    <= work_next;
        bout <= bit_borrow;
      end
    end
  end

endmodule
